// File: rtl/uart_io_bridge_pkg.sv
// Shared UART state encodings, frame constants and baud-divider helpers
// used by the bridge top and its receive FIFO.
package uart_io_bridge_pkg;

    typedef enum logic [1:0] {
        UART_IDLE  = 2'd0,
        UART_START = 2'd1,
        UART_DATA  = 2'd2,
        UART_STOP  = 2'd3
    } uart_state_e;

    localparam int UART_FRAME_BITS = 8;
    localparam int UART_BIT_W      = $clog2(UART_FRAME_BITS);

    function automatic int uart_div(input int clk_freq, input int baud);
        return clk_freq / baud;
    endfunction

    function automatic int uart_cnt_w(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/uart_io_bridge_if.sv
// Core-side UART handshake: the core (master) requests sends and pops
// received bytes; the bridge (slave) reports busy/ready and the head byte.
interface uart_io_bridge_if #(
    parameter int WORD = 32
);
    logic            ext_uart_start;
    logic [WORD-1:0] t_data;
    logic            ext_uart_busy;
    logic            ext_uart_ready;
    logic [WORD-1:0] r_data;
    logic            ext_uart_clear;

    modport master (
        output ext_uart_start, t_data, ext_uart_clear,
        input  ext_uart_busy, ext_uart_ready, r_data
    );

    modport slave (
        input  ext_uart_start, t_data, ext_uart_clear,
        output ext_uart_busy, ext_uart_ready, r_data
    );
endinterface

// File: rtl/uart_io_bridge_rx_fifo.sv
// Show-ahead receive FIFO: head entry is visible combinationally, a push
// into a full FIFO without a same-cycle pop is dropped and flagged.
module uart_io_bridge_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             overrun_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             overrun_q, overrun_d;
    logic             do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CW'(DEPTH));
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q | (push_i & full_o & ~do_pop);
        if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // NOTE: storage is not reset; the count guards every read, so stale contents are never visible.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o    = empty_o ? '0 : mem_q[rd_ptr_q];
    assign overrun_o = overrun_q;

endmodule

// File: rtl/uart_io_bridge.sv
// Board-side UART for the CPU core: 8N1 transmitter and mid-bit sampling
// receiver feeding a show-ahead FIFO, both running independently.
module uart_io_bridge
    import uart_io_bridge_pkg::*;
#(
    parameter int CLK_FREQ = 50000000,
    parameter int BAUD     = 9600,
    parameter int RX_DEPTH = 4,
    parameter int WORD     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rxd,
    output logic              txd,
    output logic              rx_overrun,
    output logic              rx_frame_err,
    uart_io_bridge_if.slave   bus
);
    localparam int                    DIV      = uart_div(CLK_FREQ, BAUD);
    localparam int                    CW       = uart_cnt_w(DIV);
    localparam logic [CW-1:0]         DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0]         DIV_HALF = CW'(DIV / 2);
    localparam logic [UART_BIT_W-1:0] LAST_BIT = UART_BIT_W'(UART_FRAME_BITS - 1);

    uart_state_e                tx_state_q, tx_state_d;
    logic [CW-1:0]              tx_cnt_q, tx_cnt_d;
    logic [UART_BIT_W-1:0]      tx_bit_q, tx_bit_d;
    logic [UART_FRAME_BITS-1:0] tx_shift_q, tx_shift_d;
    logic                       tx_tick;

    uart_state_e                rx_state_q, rx_state_d;
    logic [CW-1:0]              rx_cnt_q, rx_cnt_d;
    logic [UART_BIT_W-1:0]      rx_bit_q, rx_bit_d;
    logic [UART_FRAME_BITS-1:0] rx_shift_q, rx_shift_d;
    logic                       rx_meta_q, rx_sync_q, rx_prev_q;
    logic                       rx_frame_err_q;
    logic                       rx_sample, rx_fall, rx_push, rx_err_set;

    logic [UART_FRAME_BITS-1:0] rx_head;
    logic                       rx_empty, rx_full;
    logic                       unused_bits;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= UART_IDLE;
            tx_cnt_q   <= '0;
            tx_bit_q   <= '0;
            tx_shift_q <= '0;
        end else begin
            tx_state_q <= tx_state_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_bit_q   <= tx_bit_d;
            tx_shift_q <= tx_shift_d;
        end
    end

    assign tx_tick = (tx_cnt_q == DIV_LAST);

    // Each non-idle state lasts DIV cycles; tx_cnt wraps to zero on tx_tick.
    always_comb begin
        tx_state_d = tx_state_q;
        tx_cnt_d   = tx_tick ? '0 : tx_cnt_q + CW'(1);
        tx_bit_d   = tx_bit_q;
        tx_shift_d = tx_shift_q;
        case (tx_state_q)
            UART_IDLE: begin
                tx_cnt_d = '0;
                if (bus.ext_uart_start) begin
                    tx_state_d = UART_START;
                    tx_shift_d = bus.t_data[UART_FRAME_BITS-1:0];
                end
            end
            UART_START: if (tx_tick) begin
                tx_state_d = UART_DATA;
                tx_bit_d   = '0;
            end
            UART_DATA: if (tx_tick) begin
                tx_shift_d = tx_shift_q >> 1;
                tx_bit_d   = tx_bit_q + UART_BIT_W'(1);
                if (tx_bit_q == LAST_BIT) tx_state_d = UART_STOP;
            end
            UART_STOP: if (tx_tick) tx_state_d = UART_IDLE;
            default: tx_state_d = UART_IDLE;
        endcase
    end

    always_comb begin
        bus.ext_uart_busy = (tx_state_q != UART_IDLE);
        case (tx_state_q)
            UART_START: txd = 1'b0;
            UART_DATA:  txd = tx_shift_q[0];
            default:    txd = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_q      <= 1'b1;
            rx_sync_q      <= 1'b1;
            rx_prev_q      <= 1'b1;
            rx_state_q     <= UART_IDLE;
            rx_cnt_q       <= '0;
            rx_bit_q       <= '0;
            rx_shift_q     <= '0;
            rx_frame_err_q <= 1'b0;
        end else begin
            rx_meta_q      <= rxd;
            rx_sync_q      <= rx_meta_q;
            rx_prev_q      <= rx_sync_q;
            rx_state_q     <= rx_state_d;
            rx_cnt_q       <= rx_cnt_d;
            rx_bit_q       <= rx_bit_d;
            rx_shift_q     <= rx_shift_d;
            rx_frame_err_q <= rx_frame_err_q | rx_err_set;
        end
    end

    assign rx_sample = (rx_cnt_q == '0);
    assign rx_fall   = rx_prev_q & ~rx_sync_q;

    // Half-bit offset on the start edge puts every later sample at mid-bit.
    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_sample ? DIV_LAST : rx_cnt_q - CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        case (rx_state_q)
            UART_IDLE: begin
                rx_cnt_d = DIV_HALF;
                if (rx_fall) rx_state_d = UART_START;
            end
            UART_START: if (rx_sample) begin
                rx_state_d = rx_sync_q ? UART_IDLE : UART_DATA;
                rx_bit_d   = '0;
            end
            UART_DATA: if (rx_sample) begin
                rx_shift_d = {rx_sync_q, rx_shift_q[UART_FRAME_BITS-1:1]};
                rx_bit_d   = rx_bit_q + UART_BIT_W'(1);
                if (rx_bit_q == LAST_BIT) rx_state_d = UART_STOP;
            end
            UART_STOP: if (rx_sample) rx_state_d = UART_IDLE;
            default: rx_state_d = UART_IDLE;
        endcase
    end

    always_comb begin
        rx_push    = (rx_state_q == UART_STOP) & rx_sample & rx_sync_q;
        rx_err_set = (rx_state_q == UART_STOP) & rx_sample & ~rx_sync_q;
    end

    uart_io_bridge_rx_fifo #(
        .DEPTH (RX_DEPTH),
        .WIDTH (UART_FRAME_BITS)
    ) u_rx_fifo (
        .clk       (clk),
        .rst       (rst),
        .push_i    (rx_push),
        .data_i    (rx_shift_q),
        .pop_i     (bus.ext_uart_clear),
        .data_o    (rx_head),
        .empty_o   (rx_empty),
        .full_o    (rx_full),
        .overrun_o (rx_overrun)
    );

    assign bus.ext_uart_ready = ~rx_empty;
    assign bus.r_data         = {{(WORD-UART_FRAME_BITS){1'b0}}, rx_head};
    assign rx_frame_err       = rx_frame_err_q;
    assign unused_bits        = ^{bus.t_data[WORD-1:UART_FRAME_BITS], rx_full};

endmodule

// File: tb/tb_uart_io_bridge.sv
// Scenario bench for uart_io_bridge at DIV=16: expected line waveforms and
// received bytes come from frame arithmetic and a queue model of the FIFO.
module tb_uart_io_bridge;
    localparam int CLK_FREQ = 16;
    localparam int BAUD     = 1;
    localparam int DIV      = CLK_FREQ / BAUD;
    localparam int RX_DEPTH = 4;
    localparam int WORD     = 32;

    logic clk = 1'b0;
    logic rst, rxd, rxd_drv, loop_en, txd, rx_overrun, rx_frame_err;
    int   n_cmp = 0;
    int   n_bad = 0;

    uart_io_bridge_if #(.WORD(WORD)) bus ();

    assign rxd = loop_en ? txd : rxd_drv;

    uart_io_bridge #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .RX_DEPTH (RX_DEPTH),
        .WORD     (WORD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .rxd          (rxd),
        .txd          (txd),
        .rx_overrun   (rx_overrun),
        .rx_frame_err (rx_frame_err),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit, got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Line level for bit slot idx of an 8N1 frame: start, 8 data LSB first, stop.
    function automatic logic frame_bit(input logic [7:0] b, input int idx, input logic stop);
        if (idx == 0) return 1'b0;
        if (idx >= 9) return stop;
        return b[idx-1];
    endfunction

    task automatic apply_reset();
        rst = 1'b1;
        bus.ext_uart_start = 1'b0;
        bus.ext_uart_clear = 1'b0;
        rxd_drv = 1'b1;
        loop_en = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic pop_head();
        bus.ext_uart_clear = 1'b1;
        tick();
        bus.ext_uart_clear = 1'b0;
    endtask

    task automatic send_rx_frame(input logic [7:0] b, input logic stop);
        for (int i = 0; i < 10; i++) begin
            rxd_drv = frame_bit(b, i, stop);
            repeat (DIV) tick();
        end
        rxd_drv = 1'b1;
    endtask

    task automatic wait_ready(input int budget, output bit ok);
        for (int i = 0; i < budget && bus.ext_uart_ready !== 1'b1; i++) tick();
        ok = (bus.ext_uart_ready === 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL reset_txd: got %b want 1", txd); end
        n_cmp++; if (bus.ext_uart_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.ext_uart_busy); end
        n_cmp++; if (bus.ext_uart_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", bus.ext_uart_ready); end
        n_cmp++; if (bus.r_data !== 32'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", bus.r_data); end
        n_cmp++; if (rx_overrun !== 1'b0) begin n_bad++; $display("FAIL reset_overrun: got %b want 0", rx_overrun); end
        n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL reset_frame_err: got %b want 0", rx_frame_err); end
    endtask

    task automatic test_tx_frame();
        int   busy_cycles;
        logic exp_txd;
        apply_reset();
        busy_cycles = 0;
        bus.t_data = 32'h12345655;
        bus.ext_uart_start = 1'b1;
        tick();
        bus.ext_uart_start = 1'b0;
        for (int c = 0; c < 180; c++) begin
            exp_txd = (c < 10 * DIV) ? frame_bit(8'h55, c / DIV, 1'b1) : 1'b1;
            n_cmp++;
            if (txd !== exp_txd) begin
                n_bad++; $display("FAIL tx_line cycle %0d: got %b want %b", c, txd, exp_txd);
            end
            if (bus.ext_uart_busy === 1'b1) busy_cycles++;
            if (c == 50) begin
                bus.t_data = 32'hFFFFFF00;
                bus.ext_uart_start = 1'b1;
            end else begin
                bus.ext_uart_start = 1'b0;
            end
            tick();
        end
        n_cmp++;
        if (busy_cycles != 10 * DIV) begin
            n_bad++; $display("FAIL tx_busy_len: got %0d want %0d", busy_cycles, 10 * DIV);
        end
    endtask

    task automatic test_rx_single();
        int rise;
        apply_reset();
        rise = -1;
        for (int c = 0; c < 200; c++) begin
            rxd_drv = (c < 10 * DIV) ? frame_bit(8'hA3, c / DIV, 1'b1) : 1'b1;
            tick();
            if (rise < 0 && bus.ext_uart_ready === 1'b1) rise = c + 1;
        end
        n_cmp++;
        if (rise < 150 || rise > 162) begin
            n_bad++; $display("FAIL rx_ready_latency: got %0d want 150..162", rise);
        end
        n_cmp++; if (bus.r_data !== 32'h000000A3) begin n_bad++; $display("FAIL rx_rdata: got %h want 000000a3", bus.r_data); end
        pop_head();
        n_cmp++; if (bus.ext_uart_ready !== 1'b0) begin n_bad++; $display("FAIL rx_pop_ready: got %b want 0", bus.ext_uart_ready); end
        n_cmp++; if (bus.r_data !== 32'h0) begin n_bad++; $display("FAIL rx_pop_rdata: got %h want 0", bus.r_data); end
        pop_head();
        send_rx_frame(8'h5A, 1'b1);
        tick();
        n_cmp++; if (bus.r_data !== 32'h0000005A) begin n_bad++; $display("FAIL rx_after_empty_pop: got %h want 0000005a", bus.r_data); end
        pop_head();
        n_cmp++; if (bus.ext_uart_ready !== 1'b0) begin n_bad++; $display("FAIL rx_no_underflow: got %b want 0", bus.ext_uart_ready); end
    endtask

    task automatic test_glitch();
        apply_reset();
        rxd_drv = 1'b0;
        repeat (4) tick();
        rxd_drv = 1'b1;
        repeat (40) tick();
        n_cmp++; if (bus.ext_uart_ready !== 1'b0) begin n_bad++; $display("FAIL glitch_ready: got %b want 0", bus.ext_uart_ready); end
        n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL glitch_frame_err: got %b want 0", rx_frame_err); end
        n_cmp++; if (rx_overrun !== 1'b0) begin n_bad++; $display("FAIL glitch_overrun: got %b want 0", rx_overrun); end
        send_rx_frame(8'hC6, 1'b1);
        tick();
        n_cmp++; if (bus.r_data !== 32'h000000C6) begin n_bad++; $display("FAIL glitch_then_frame: got %h want 000000c6", bus.r_data); end
        pop_head();
    endtask

    task automatic test_overrun();
        logic [7:0] q[$];
        logic [7:0] exp;
        bit         model_ovr;
        apply_reset();
        model_ovr = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            send_rx_frame(8'(k), 1'b1);
            if (q.size() < RX_DEPTH) q.push_back(8'(k));
            else model_ovr = 1'b1;
        end
        repeat (4) tick();
        n_cmp++; if (rx_overrun !== model_ovr) begin n_bad++; $display("FAIL overrun_flag: got %b want %b", rx_overrun, model_ovr); end
        while (q.size() != 0) begin
            exp = q.pop_front();
            n_cmp++; if (bus.ext_uart_ready !== 1'b1) begin n_bad++; $display("FAIL overrun_ready: got %b want 1", bus.ext_uart_ready); end
            n_cmp++; if (bus.r_data !== {24'h0, exp}) begin n_bad++; $display("FAIL overrun_pop: got %h want %h", bus.r_data, {24'h0, exp}); end
            pop_head();
        end
        n_cmp++; if (bus.ext_uart_ready !== 1'b0) begin n_bad++; $display("FAIL overrun_drained: got %b want 0", bus.ext_uart_ready); end
        n_cmp++; if (rx_overrun !== 1'b1) begin n_bad++; $display("FAIL overrun_sticky: got %b want 1", rx_overrun); end
    endtask

    task automatic test_frame_err();
        send_rx_frame(8'h7E, 1'b0);
        repeat (20) tick();
        n_cmp++; if (bus.ext_uart_ready !== 1'b0) begin n_bad++; $display("FAIL ferr_no_push: got %b want 0", bus.ext_uart_ready); end
        n_cmp++; if (rx_frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_flag: got %b want 1", rx_frame_err); end
        send_rx_frame(8'h55, 1'b1);
        tick();
        n_cmp++; if (bus.r_data !== 32'h00000055) begin n_bad++; $display("FAIL ferr_next_frame: got %h want 00000055", bus.r_data); end
        pop_head();
        n_cmp++; if (rx_frame_err !== 1'b1) begin n_bad++; $display("FAIL ferr_sticky: got %b want 1", rx_frame_err); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok;
        bus.t_data = 32'h000000A5;
        bus.ext_uart_start = 1'b1;
        rxd_drv = 1'b0;
        tick();
        bus.ext_uart_start = 1'b0;
        for (int c = 1; c < 70; c++) begin
            rxd_drv = frame_bit(8'h99, c / DIV, 1'b1);
            tick();
        end
        rst = 1'b1;
        rxd_drv = 1'b1;
        tick();
        rst = 1'b0;
        n_cmp++; if (txd !== 1'b1) begin n_bad++; $display("FAIL midrst_txd: got %b want 1", txd); end
        n_cmp++; if (bus.ext_uart_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy: got %b want 0", bus.ext_uart_busy); end
        n_cmp++; if (bus.ext_uart_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_ready: got %b want 0", bus.ext_uart_ready); end
        n_cmp++; if (rx_overrun !== 1'b0) begin n_bad++; $display("FAIL midrst_overrun: got %b want 0", rx_overrun); end
        n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL midrst_frame_err: got %b want 0", rx_frame_err); end
        repeat (40) tick();
        n_cmp++; if (bus.ext_uart_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_no_garbage: got %b want 0", bus.ext_uart_ready); end
        loop_en = 1'b1;
        bus.t_data = 32'h0000003C;
        bus.ext_uart_start = 1'b1;
        tick();
        bus.ext_uart_start = 1'b0;
        wait_ready(400, ok);
        n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL midrst_fresh_timeout: got %b want 1", ok); end
        n_cmp++; if (bus.r_data !== 32'h0000003C) begin n_bad++; $display("FAIL midrst_fresh_data: got %h want 0000003c", bus.r_data); end
        for (int i = 0; i < 40 && bus.ext_uart_busy === 1'b1; i++) tick();
        n_cmp++; if (bus.ext_uart_busy !== 1'b0) begin n_bad++; $display("FAIL midrst_fresh_busy: got %b want 0", bus.ext_uart_busy); end
        n_cmp++; if (rx_frame_err !== 1'b0) begin n_bad++; $display("FAIL midrst_fresh_ferr: got %b want 0", rx_frame_err); end
        pop_head();
    endtask

    task automatic test_full_duplex();
        logic [7:0]  a, b;
        logic [31:0] td;
        logic        exp_txd;
        apply_reset();
        for (int it = 0; it < 3; it++) begin
            a  = 8'($urandom());
            b  = 8'($urandom());
            td = $urandom();
            td[7:0] = a;
            bus.t_data = td;
            bus.ext_uart_start = 1'b1;
            rxd_drv = 1'b0;
            tick();
            bus.ext_uart_start = 1'b0;
            for (int c = 0; c < 170; c++) begin
                exp_txd = (c < 10 * DIV) ? frame_bit(a, c / DIV, 1'b1) : 1'b1;
                n_cmp++;
                if (txd !== exp_txd) begin
                    n_bad++; $display("FAIL duplex_tx it%0d cycle %0d: got %b want %b", it, c, txd, exp_txd);
                end
                rxd_drv = (c + 1 < 10 * DIV) ? frame_bit(b, (c + 1) / DIV, 1'b1) : 1'b1;
                tick();
            end
            n_cmp++; if (bus.r_data !== {24'h0, b}) begin n_bad++; $display("FAIL duplex_rx it%0d: got %h want %h", it, bus.r_data, {24'h0, b}); end
            n_cmp++; if (bus.ext_uart_busy !== 1'b0) begin n_bad++; $display("FAIL duplex_busy it%0d: got %b want 0", it, bus.ext_uart_busy); end
            pop_head();
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0]  q[$];
        logic [7:0]  b, exp;
        logic [31:0] td;
        bit          ok;
        apply_reset();
        loop_en = 1'b1;
        for (int n = 0; n < 5; n++) begin
            for (int i = 0; i < 40 && bus.ext_uart_busy === 1'b1; i++) tick();
            n_cmp++; if (bus.ext_uart_busy !== 1'b0) begin n_bad++; $display("FAIL b2b_idle %0d: got %b want 0", n, bus.ext_uart_busy); end
            b  = 8'($urandom());
            td = $urandom();
            td[7:0] = b;
            bus.t_data = td;
            bus.ext_uart_start = 1'b1;
            tick();
            bus.ext_uart_start = 1'b0;
            n_cmp++; if (bus.ext_uart_busy !== 1'b1) begin n_bad++; $display("FAIL b2b_accept %0d: got %b want 1", n, bus.ext_uart_busy); end
            q.push_back(b);
            wait_ready(400, ok);
            n_cmp++; if (ok !== 1'b1) begin n_bad++; $display("FAIL b2b_timeout %0d: got %b want 1", n, ok); end
            exp = q.pop_front();
            n_cmp++; if (bus.r_data !== {24'h0, exp}) begin n_bad++; $display("FAIL b2b_data %0d: got %h want %h", n, bus.r_data, {24'h0, exp}); end
            pop_head();
        end
        n_cmp++; if (bus.ext_uart_ready !== 1'b0) begin n_bad++; $display("FAIL b2b_drained: got %b want 0", bus.ext_uart_ready); end
    endtask

    initial begin
        rst = 1'b1;
        rxd_drv = 1'b1;
        loop_en = 1'b0;
        bus.ext_uart_start = 1'b0;
        bus.ext_uart_clear = 1'b0;
        bus.t_data = '0;
        test_reset();
        test_tx_frame();
        test_rx_single();
        test_glitch();
        test_overrun();
        test_frame_err();
        test_reset_mid_frame();
        test_full_duplex();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/uart_io_bridge.md
Name: uart_io_bridge

Overview:
- Board-level serial peripheral feeding the CPU core's UART handshake port: ext_uart_ready/busy/clear/start, r_data, t_data.
- Transmits the low byte of t_data on a 1-start / 8-data / 1-stop, no-parity line.
- Receives bytes into a small show-ahead FIFO. The head byte is presented zero-extended to WORD for the MEM stage's UART load path.
- Sits between the core top and the board pins, beside the base/ext SRAM interface.

Parameters:
CLK_FREQ, 50000000, system clock frequency in Hz
BAUD, 9600, line rate; DIV = CLK_FREQ/BAUD (integer, must be >= 4)
RX_DEPTH, 4, receive FIFO entries, power of two
WORD, 32, CPU data width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
rxd  in  1  serial input from pin, asynchronous
txd  out  1  serial output to pin, idles high
ext_uart_start  in  1  core request to send t_data[7:0]
t_data  in  WORD  transmit data; only [7:0] used
ext_uart_busy  out  1  transmitter not idle
ext_uart_ready  out  1  receive FIFO non-empty
r_data  out  WORD  {24'b0, FIFO head byte}; 0 when empty
ext_uart_clear  in  1  core consumed head byte (pop)
rx_overrun  out  1  sticky: byte dropped because FIFO full
rx_frame_err  out  1  sticky: stop bit sampled low

Behaviour:
- Reset: synchronous, one cycle, may arrive mid-frame.
  - Outputs next edge: txd=1, busy=0, ready=0, r_data=0, rx_overrun=0, rx_frame_err=0.
  - FIFO emptied; both FSMs go to IDLE; baud counters cleared.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE with start=1: latch t_data[7:0], go to START; busy=1 from the next cycle.
  - Each state holds exactly DIV cycles: START txd=0; DATA 8 bits LSB first; STOP txd=1.
  - End of STOP: go to IDLE, busy=0. Frame = 10*DIV cycles of busy.
  - start while busy=1 is ignored; the core must poll busy.
  - start in the same cycle busy falls is not accepted; accepted the following cycle.
- RX input: rxd passes a 2-flop synchronizer, giving 2 cycles of added latency.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: falling edge of synchronized rxd → START, counter = DIV/2.
  - START: at mid-bit, if rxd=1 it is a glitch → IDLE, nothing recorded. Otherwise go to DATA.
  - DATA: sample each bit every DIV cycles, LSB first, into a shift register.
  - STOP: sample once at mid stop bit.
    - If 1: push byte.
    - If 0: discard byte, set rx_frame_err.
    - Then IDLE; a new start edge is accepted immediately.
- FIFO (RX_DEPTH entries, pointers wrap modulo RX_DEPTH, count 0..RX_DEPTH):
  - ready = (count != 0); r_data is combinational from the head entry (show-ahead).
  - clear with ready=1 pops the head, visible next cycle; clear with ready=0 is ignored.
  - Push when full without simultaneous pop: byte dropped, rx_overrun set.
  - Push when full with simultaneous pop: both happen, count unchanged, no overrun.
  - Push when empty: ready=1 the cycle after the stop-bit sample (no bypass).
- Sticky flags clear only on rst.
- TX and RX are fully independent; full-duplex operation is required.

Decomposition:
- Shared package/header (alongside CPU_Parameter.vh):
  - UART state encodings: UART_IDLE/START/DATA/STOP, 2 bits.
  - UART_FRAME_BITS=8.
  - Macro computing DIV and its counter width as clog2(DIV).
- One sub-module, uart_rx_fifo: parameterized show-ahead FIFO with push/pop/full/empty/overrun.
- TX and RX FSMs stay in the top module.

Test Plan:
- CLK_FREQ=16, BAUD=1 (DIV=16); pulse start with t_data=0x12345655 → txd holds 0,1,0,1,0,1,0,1,0,1 for 16 cycles each; busy high exactly 160 cycles; second start issued at cycle 50 is ignored.
- Drive rxd with frame for 0xA3 at DIV=16 → ready rises ~(2+8+9*16) cycles after the start edge, r_data=0x000000A3; pulse clear → ready=0, r_data=0 next cycle.
- Send 5 bytes 0x01..0x05 with no clear (RX_DEPTH=4) → rx_overrun=1; successive pops return 0x01,0x02,0x03,0x04, then ready=0.
- rxd low for 4 cycles then high → no byte pushed, no error flags, RX back in IDLE.
- Frame 0x7E with stop bit driven 0 → no push, rx_frame_err=1; next valid frame 0x55 received correctly.
- Assert rst at TX cycle 70 and mid RX DATA → next cycle txd=1, busy=0, ready=0, flags 0; a fresh 0x3C transmits and receives cleanly afterward.
